io_port: RTL and testbench

IO_PORT -- requirements
Module: io_port

---
 rtl/io_port.sv | 170 +++++++++++++++++
 tb/tb_io_port.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port.sv
// io_port: CPU-side strobed read/write port bridged to host-side valid/ready
// streams through two independent FIFOs. The input FIFO carries host words to the
// CPU and the output FIFO carries CPU words to the host. Sticky flags record CPU
// reads of an empty input FIFO and CPU writes that were dropped.

// Single-clock FIFO with a combinational head and an explicit count.
// The parent qualifies push/pop, so this block never checks for full or empty.
module io_port_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset_n_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Storage is not reset. Reads are qualified by the count, so stale contents
  // are never visible.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state for the pointers and the count. The pointers wrap naturally at
  // the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers. These are cleared asynchronously, so the FIFO
  // reads as empty as soon as reset is asserted.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // The head is combinational from storage and forced to zero when the FIFO is empty.
  always_comb begin
    head_o = '0;
    if (count_q != '0) begin
      head_o = mem_q[rd_ptr_q];
    end
  end

  assign count_o = count_q;

endmodule

// Top level: the two FIFOs plus the strobe qualification and the sticky error flags.
module io_port #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_signal,
  output logic [WIDTH-1:0] in_data,
  input  logic             out_signal,
  input  logic [WIDTH-1:0] out_data,
  input  logic             host_in_valid,
  input  logic [WIDTH-1:0] host_in_data,
  output logic             host_in_ready,
  output logic             host_out_valid,
  output logic [WIDTH-1:0] host_out_data,
  input  logic             host_out_ready,
  output logic             underflow,
  output logic             overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] in_count, out_count;
  logic          in_push, in_pop;
  logic          out_push, out_pop;
  logic          underflow_q, underflow_d;
  logic          overflow_q, overflow_d;

  // Host-to-CPU direction. Ready comes only from the registered count, so a full
  // FIFO never passes a word through, even when the CPU reads in the same cycle.
  always_comb begin
    host_in_ready = (in_count < FULL_CNT);
    in_push       = host_in_valid && host_in_ready;
    in_pop        = in_signal && (in_count != '0);
  end

  // CPU-to-host direction. A full FIFO still accepts a write when the host
  // drains a word on the same edge, because that frees a slot.
  always_comb begin
    host_out_valid = (out_count != '0);
    out_pop        = host_out_valid && host_out_ready;
    out_push       = out_signal && ((out_count < FULL_CNT) || out_pop);
  end

  // Sticky error flags. Once set, only reset clears them.
  always_comb begin
    underflow_d = underflow_q | (in_signal && (in_count == '0));
    overflow_d  = overflow_q  | (out_signal && !out_push);
  end

  // Flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign underflow = underflow_q;
  assign overflow  = overflow_q;

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in_fifo (
    .clk       (clk),
    .reset_n_i (reset),
    .push_i    (in_push),
    .pop_i     (in_pop),
    .wdata_i   (host_in_data),
    .count_o   (in_count),
    .head_o    (in_data)
  );

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out_fifo (
    .clk       (clk),
    .reset_n_i (reset),
    .push_i    (out_push),
    .pop_i     (out_pop),
    .wdata_i   (out_data),
    .count_o   (out_count),
    .head_o    (host_out_data)
  );

endmodule

// File: tb/tb_io_port.sv
// Scoreboard testbench for io_port. Each transaction cycle records the words the
// port should accept in per-direction queues. Heads, ready/valid and the sticky
// flags are then compared against those queues.
module tb_io_port;

  localparam int DEPTH = 8;
  localparam int WIDTH = 64;

  logic             clk;
  logic             reset;
  logic             in_signal;
  logic [WIDTH-1:0] in_data;
  logic             out_signal;
  logic [WIDTH-1:0] out_data;
  logic             host_in_valid;
  logic [WIDTH-1:0] host_in_data;
  logic             host_in_ready;
  logic             host_out_valid;
  logic [WIDTH-1:0] host_out_data;
  logic             host_out_ready;
  logic             underflow;
  logic             overflow;

  io_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_signal      (in_signal),
    .in_data        (in_data),
    .out_signal     (out_signal),
    .out_data       (out_data),
    .host_in_valid  (host_in_valid),
    .host_in_data   (host_in_data),
    .host_in_ready  (host_in_ready),
    .host_out_valid (host_out_valid),
    .host_out_data  (host_out_data),
    .host_out_ready (host_out_ready),
    .underflow      (underflow),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] in_q[$];
  logic [WIDTH-1:0] out_q[$];
  logic             exp_unf;
  logic             exp_ovf;
  int               vectors;
  int               miscompares;
  int               cyc;

  task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus. The task checks the outputs before the edge, updates
  // the scoreboard, and after the edge checks the flags.
  task automatic cycle(input logic rd, input logic hv, input logic [WIDTH-1:0] hd,
                       input logic wr, input logic [WIDTH-1:0] wd, input logic hr,
                       output bit in_acc);
    int  isz;
    int  osz;
    bit  o_pop;
    bit  o_acc;
    isz = in_q.size();
    osz = out_q.size();
    in_signal      = rd;
    host_in_valid  = hv;
    host_in_data   = hd;
    out_signal     = wr;
    out_data       = wd;
    host_out_ready = hr;
    #1;
    check_val("host_in_ready", WIDTH'(host_in_ready), WIDTH'(isz < DEPTH));
    check_val("in_data", in_data, (isz != 0) ? in_q[0] : '0);
    check_val("host_out_valid", WIDTH'(host_out_valid), WIDTH'(osz != 0));
    check_val("host_out_data", host_out_data, (osz != 0) ? out_q[0] : '0);
    in_acc = hv && (isz < DEPTH);
    o_pop  = (osz != 0) && hr;
    o_acc  = wr && ((osz < DEPTH) || o_pop);
    if (rd && isz == 0) exp_unf = 1'b1;
    if (wr && !o_acc)   exp_ovf = 1'b1;
    if (rd && isz != 0) void'(in_q.pop_front());
    if (in_acc)         in_q.push_back(hd);
    if (o_pop)          void'(out_q.pop_front());
    if (o_acc)          out_q.push_back(wd);
    $display("cyc %0d rd=%0b hv=%0b hd=%0h wr=%0b wd=%0h hr=%0b in_acc=%0b out_acc=%0b",
             cyc, rd, hv, hd, wr, wd, hr, in_acc, o_acc);
    cyc++;
    @(posedge clk);
    #1;
    check_val("underflow", WIDTH'(underflow), WIDTH'(exp_unf));
    check_val("overflow", WIDTH'(overflow), WIDTH'(exp_ovf));
  endtask

  task automatic idle();
    bit a;
    cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, WIDTH'(host_in_ready), WIDTH'(1));
    check_val({tag, "_out_valid"}, WIDTH'(host_out_valid), WIDTH'(0));
    check_val({tag, "_in_data"}, in_data, '0);
    check_val({tag, "_out_data"}, host_out_data, '0);
    check_val({tag, "_underflow"}, WIDTH'(underflow), WIDTH'(0));
    check_val({tag, "_overflow"}, WIDTH'(overflow), WIDTH'(0));
  endtask

  initial begin
    bit acc;
    int k;
    int guard;
    int wi;
    int wo;
    vectors = 0; miscompares = 0; cyc = 0;
    exp_unf = 1'b0; exp_ovf = 1'b0;
    in_signal = 0; host_in_valid = 0; host_in_data = '0;
    out_signal = 0; out_data = '0; host_out_ready = 0;
    reset = 1'b0;
    #12;
    check_reset_outputs("rst");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Host pushes 5,6,7, then the CPU reads them with single-cycle strobes.
    cycle(0, 1, 64'd5, 0, '0, 0, acc);
    cycle(0, 1, 64'd6, 0, '0, 0, acc);
    cycle(0, 1, 64'd7, 0, '0, 0, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, '0, 0, '0, 0, acc);
      idle();
    end
    idle();

    // A read of the empty FIFO in the same cycle as a host push of 9.
    cycle(1, 1, 64'd9, 0, '0, 0, acc);
    cycle(1, 0, '0, 0, '0, 0, acc);
    idle();

    // Fill the input FIFO with valid held. The 9th word waits for one CPU read.
    k = 0; guard = 0;
    while (k < DEPTH && guard < 50) begin
      cycle(0, 1, 64'd100 + 64'(k), 0, '0, 0, acc);
      if (acc) k++;
      guard++;
    end
    check_val("fill_in_timeout", 64'(k), 64'(DEPTH));
    cycle(1, 1, 64'd108, 0, '0, 0, acc);
    check_val("ninth_held", 64'(acc), 64'd0);
    cycle(0, 1, 64'd108, 0, '0, 0, acc);
    check_val("ninth_taken", 64'(acc), 64'd1);
    guard = 0;
    while (in_q.size() != 0 && guard < 50) begin
      cycle(1, 0, '0, 0, '0, 0, acc);
      guard++;
    end
    check_val("drain_in_timeout", 64'(in_q.size()), 64'd0);

    // Fill the output FIFO, then write 42 on a full FIFO while the host pops.
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, '0, 1, 64'd10 + 64'(i), 0, acc);
    cycle(0, 0, '0, 1, 64'd42, 1, acc);
    check_val("out_full_after_42", 64'(out_q.size()), 64'(DEPTH));
    guard = 0;
    while (out_q.size() != 0 && guard < 50) begin
      cycle(0, 0, '0, 0, '0, 1, acc);
      guard++;
    end
    idle();

    // The CPU writes 1..9 while the host stalls; the 9th write overflows. The host then drains.
    for (int i = 1; i <= DEPTH + 1; i++) cycle(0, 0, '0, 1, 64'(i), 0, acc);
    check_val("out_q_len", 64'(out_q.size()), 64'(DEPTH));
    guard = 0;
    while (out_q.size() != 0 && guard < 50) begin
      cycle(0, 0, '0, 0, '0, 1, acc);
      guard++;
    end
    idle();

    // Queue 3 words in each FIFO, then pulse reset between clock edges.
    for (int i = 0; i < 3; i++) cycle(0, 1, 64'd50 + 64'(i), 1, 64'd60 + 64'(i), 0, acc);
    in_signal = 0; host_in_valid = 0; out_signal = 0; host_out_ready = 0;
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #1 reset = 1'b1;
    in_q.delete(); out_q.delete();
    exp_unf = 1'b0; exp_ovf = 1'b0;

    // Wrap test: 20 words through each FIFO with randomly paced consumers.
    wi = 0; wo = 0; guard = 0;
    while ((wi < 20 || wo < 20 || in_q.size() != 0 || out_q.size() != 0) && guard < 400) begin
      logic rd;
      logic wr;
      rd = (in_q.size() != 0) && ($urandom_range(0, 2) != 0);
      wr = (wo < 20) && (out_q.size() < DEPTH);
      cycle(rd, wi < 20, 64'd1000 + 64'(wi), wr, 64'd2000 + 64'(wo),
            $urandom_range(0, 2) != 0, acc);
      if (acc && wi < 20) wi++;
      if (wr) wo++;
      guard++;
    end
    check_val("wrap_timeout", 64'(guard < 400), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
